// File: rtl/i2c_alu_pkg.sv
// i2c_alu_pkg: shared FSM state encoding and register map for the I2C ALU target.
package i2c_alu_pkg;
    typedef enum logic [3:0] {
        IDLE, RX_ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_DATA, RX_ACK
    } state_t;
    localparam logic [7:0] REG_A         = 8'h00;
    localparam logic [7:0] REG_B         = 8'h01;
    localparam logic [7:0] REG_CIN       = 8'h02;
    localparam logic [7:0] REG_SUM       = 8'h03;
    localparam logic [7:0] REG_COUT      = 8'h04;
    localparam logic [7:0] READ_UNMAPPED = 8'hFF;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: SCL/SDA synchronisers with SCL edge and START/STOP detection.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl, scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl        = scl_sync_q[SYNC_STAGES-1];
        sda        = sda_sync_q[SYNC_STAGES-1];
        scl_prev_d = scl;
        sda_prev_d = sda;
        scl_rise   = scl & ~scl_prev_q;
        scl_fall   = ~scl & scl_prev_q;
        start      = scl & scl_prev_q & sda_prev_q & ~sda;
        stop       = scl & scl_prev_q & ~sda_prev_q & sda;
    end

    // Reset to all-ones so an idle bus produces no spurious edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end
endmodule

// File: rtl/i2c_alu_target.sv
// i2c_alu_target: I2C target exposing ALU operands/results as a register map.
// Define I2C_ALU_AUTOINC_EN to auto-increment the pointer on each data byte.
module i2c_alu_target
    import i2c_alu_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    input  logic [7:0] alu_sum,
    input  logic [2:0] alu_cout,
    output logic       reg_wr
);
    localparam logic [7:0] NREG = 8'(NUM_REGS);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, ptr_q, ptr_d, a_q, a_d, b_q, b_d;
    logic       cin_q, cin_d, sda_oe_q, sda_oe_d, reg_wr_q, reg_wr_d;
    logic       sda, scl_rise, scl_fall, start, stop, wr_ok;
    logic [7:0] rx_byte, ptr_inc, rd_ptr, rd_byte;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda(sda),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
    );

`ifdef I2C_ALU_AUTOINC_EN
    assign ptr_inc = ptr_q + 8'd1;
`else
    assign ptr_inc = ptr_q;
`endif

    always_comb begin
        rx_byte = {shift_q[6:0], sda};
        wr_ok   = (ptr_q < NREG) && (ptr_q <= REG_CIN);
        rd_ptr  = (state_q == RX_ACK) ? ptr_inc : ptr_q;
        rd_byte = (rd_ptr >= NREG)     ? READ_UNMAPPED :
                  (rd_ptr == REG_A)    ? a_q :
                  (rd_ptr == REG_B)    ? b_q :
                  (rd_ptr == REG_CIN)  ? {7'b0, cin_q} :
                  (rd_ptr == REG_SUM)  ? alu_sum :
                  (rd_ptr == REG_COUT) ? {5'b0, alu_cout} : READ_UNMAPPED;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        sda_oe_d  = sda_oe_q;
        reg_wr_d  = 1'b0;
        if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else if (start) begin
            state_d   = RX_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (scl_rise) begin
            if (state_q inside {RX_ADDR, RX_PTR, RX_DATA}) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == RX_ADDR) begin
                        state_d = (rx_byte[7:1] == TGT_ADDR) ? ACK_ADDR : IDLE;
                    end else if (state_q == RX_PTR) begin
                        ptr_d   = rx_byte;
                        state_d = ACK_PTR;
                    end else begin
                        state_d  = ACK_DATA;
                        reg_wr_d = wr_ok;
                        a_d      = (wr_ok && ptr_q == REG_A) ? rx_byte : a_q;
                        b_d      = (wr_ok && ptr_q == REG_B) ? rx_byte : b_q;
                        cin_d    = (wr_ok && ptr_q == REG_CIN) ? rx_byte[0] : cin_q;
                    end
                end
            end else if (state_q == RX_ACK && sda) begin
                state_d = IDLE;
            end
        end else if (scl_fall) begin
            if (state_q inside {ACK_ADDR, ACK_PTR, ACK_DATA}) begin
                // sda_oe doubles as the phase flag: first fall starts the ACK, second ends it.
                if (!sda_oe_q) begin
                    sda_oe_d = 1'b1;
                end else begin
                    bit_cnt_d = 3'd0;
                    sda_oe_d  = 1'b0;
                    state_d   = (state_q != ACK_ADDR) ? RX_DATA : shift_q[0] ? TX_DATA : RX_PTR;
                    ptr_d     = (state_q == ACK_DATA) ? ptr_inc : ptr_q;
                    if (state_q == ACK_ADDR && shift_q[0]) begin
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                    end
                end
            end else if (state_q == TX_DATA) begin
                shift_d   = {shift_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                sda_oe_d  = (bit_cnt_q == 3'd7) ? 1'b0 : ~shift_q[6];
                state_d   = (bit_cnt_q == 3'd7) ? RX_ACK : TX_DATA;
            end else if (state_q == RX_ACK) begin
                ptr_d     = ptr_inc;
                shift_d   = rd_byte;
                sda_oe_d  = ~rd_byte[7];
                bit_cnt_d = 3'd0;
                state_d   = TX_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            ptr_q     <= 8'd0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            cin_q     <= 1'b0;
            sda_oe_q  <= 1'b0;
            reg_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            sda_oe_q  <= sda_oe_d;
            reg_wr_q  <= reg_wr_d;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_cin = cin_q;
    assign reg_wr  = reg_wr_q;
endmodule
